// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool over non-overlapping windows of P samples per vector of L.
// Define MAXPOOL_PARTIAL_FLUSH_EN to emit the max of an incomplete final window.
module maxpool_stream #(
   parameter int T = 8,
   parameter int P = 2,
   parameter int L = 97
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                s_valid_y,
   output logic                s_ready_y,
   input  logic signed [T-1:0] s_data_in_y,
   output logic                m_valid_z,
   input  logic                m_ready_z,
   output logic signed [T-1:0] m_data_out_z
);

   localparam int WW = (P > 1) ? $clog2(P) : 1;
   localparam int VW = (L > 1) ? $clog2(L) : 1;
   localparam logic [WW-1:0] WIN_LAST = WW'(P - 1);
   localparam logic [VW-1:0] VEC_LAST = VW'(L - 1);

   logic [WW-1:0]        win_q, win_d;
   logic [VW-1:0]        vec_q, vec_d;
   logic signed [T-1:0]  max_q, max_d;
   logic signed [T-1:0]  dat_q, dat_d;
   logic                 vld_q, vld_d;

   logic                 accept;
   logic                 win_end;
   logic                 vec_end;
   logic                 emit;
   logic signed [T-1:0]  cur;

   assign s_ready_y    = ~vld_q | m_ready_z;
   assign m_valid_z    = vld_q;
   assign m_data_out_z = dat_q;

   assign accept  = s_valid_y & s_ready_y;
   assign win_end = (win_q == WIN_LAST);
   assign vec_end = (vec_q == VEC_LAST);
   assign cur     = ((win_q == '0) || (s_data_in_y > max_q)) ? s_data_in_y : max_q;

`ifdef MAXPOOL_PARTIAL_FLUSH_EN
   assign emit = accept & (win_end | vec_end);
`else
   // an incomplete window at the vector end is dropped
   assign emit = accept & win_end;
`endif

   always_comb begin
      win_d = win_q;
      vec_d = vec_q;
      max_d = max_q;
      dat_d = dat_q;
      vld_d = vld_q;
      if (vld_q && m_ready_z) begin
         vld_d = 1'b0;
      end
      if (accept) begin
         vec_d = vec_end ? '0 : vec_q + VW'(1);
         if (win_end || vec_end) begin
            win_d = '0;
         end else begin
            win_d = win_q + WW'(1);
            max_d = cur;
         end
      end
      if (emit) begin
         vld_d = 1'b1;
         dat_d = cur;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         win_q <= '0;
         vec_q <= '0;
         max_q <= '0;
         dat_q <= '0;
         vld_q <= 1'b0;
      end else begin
         win_q <= win_d;
         vec_q <= vec_d;
         max_q <= max_d;
         dat_q <= dat_d;
         vld_q <= vld_d;
      end
   end

endmodule
